// File: rtl/modulo_envase_vedacao_param_if.sv
// Plant/actuator bundle for the bottle fill/seal controller.
//   slave  : controller side (samples sensors, operator strobe and feeder ack;
//            drives actuators, alarm, feeder request and status counters)
//   master : plant/display side (the opposite directions)
// Optional DISPLAY_BCD_EN adds rolhas_bcd and garrafas_total_bcd.
interface modulo_envase_vedacao_param_if #(
  parameter int W = 7
);
  logic         enable;
  logic         pg;
  logic         ch;
  logic         cq;
  logic         add_rolhas;
  logic [W-1:0] add_valor;
  logic         refill_ack;
  logic         m;
  logic         ev;
  logic         ve;
  logic         al;
  logic [1:0]   alarm_code;
  logic         refill_req;
  logic [2:0]   estado;
  logic [W-1:0] rolhas;
  logic [3:0]   garrafas;
  logic [3:0]   duzias;
  logic         lote_fim;
`ifdef DISPLAY_BCD_EN
  logic [7:0]   rolhas_bcd;
  logic [7:0]   garrafas_total_bcd;
`endif

  modport slave (
    input  enable, pg, ch, cq, add_rolhas, add_valor, refill_ack,
`ifdef DISPLAY_BCD_EN
    output rolhas_bcd, garrafas_total_bcd,
`endif
    output m, ev, ve, al, alarm_code, refill_req, estado, rolhas,
           garrafas, duzias, lote_fim
  );

  modport master (
    output enable, pg, ch, cq, add_rolhas, add_valor, refill_ack,
`ifdef DISPLAY_BCD_EN
    input  rolhas_bcd, garrafas_total_bcd,
`endif
    input  m, ev, ve, al, alarm_code, refill_req, estado, rolhas,
           garrafas, duzias, lote_fim
  );
endinterface

// File: rtl/modulo_envase_vedacao_param.sv
// Parametrised bottle fill/seal controller.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   clr  : synchronous active-high reset, overrides every other input
//   bus  : modulo_envase_vedacao_param_if.slave
//          in : enable, pg, ch, cq, add_rolhas, add_valor, refill_ack
//          out: m, ev, ve, al, alarm_code, refill_req, estado, rolhas,
//               garrafas, duzias, lote_fim
// Optional macro DISPLAY_BCD_EN adds registered BCD views of the cork count
// (rolhas_bcd) and of the dozen count (garrafas_total_bcd).
module modulo_envase_vedacao_param #(
  parameter int W          = 7,
  parameter int CAP_MAX    = 99,
  parameter int MIN_ROLHAS = 5,
  parameter int RECARGA    = 20,
  parameter int DUZIA      = 12,
  parameter int DEZ_DUZIAS = 10,
  parameter int T_ENCHE    = 64,
  parameter int T_VEDA     = 16
) (
  input logic clk,
  input logic clr,
  modulo_envase_vedacao_param_if.slave bus
);

  localparam int TMAX = (T_ENCHE > T_VEDA) ? T_ENCHE : T_VEDA;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] T_ENCHE_LIM = TW'(T_ENCHE - 1);
  localparam logic [TW-1:0] T_VEDA_LIM  = TW'(T_VEDA - 1);
  localparam logic [W-1:0]  CAP_W       = W'(CAP_MAX);
  localparam logic [W-1:0]  MIN_W       = W'(MIN_ROLHAS);
  localparam logic [3:0]    GAR_LAST    = 4'(DUZIA - 1);
  localparam logic [3:0]    DUZ_LAST    = 4'(DEZ_DUZIAS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    AVANCA = 3'd1,
    ENCHE  = 3'd2,
    VEDA   = 3'd3,
    ALARME = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [1:0]    code, code_n;
  logic [TW-1:0] timer, timer_n;
  logic [W-1:0]  rolhas_r, rolhas_n;
  logic [3:0]    gar, duz;
  logic          lote;
  logic          req, armed;
  logic          m_r, ev_r, ve_r, al_r;
  logic          ack_accept, consume;
  logic [31:0]   soma;

  assign ack_accept = req & bus.refill_ack;
  assign consume    = (state == VEDA) & bus.enable & bus.cq & (rolhas_r != '0);

  // Refill, operator add and consume all land in the same cycle as a net sum,
  // evaluated wide enough that saturation is decided before truncation.
  always_comb begin
    soma = 32'(rolhas_r)
         + (ack_accept     ? 32'(RECARGA)       : 32'd0)
         + (bus.add_rolhas ? 32'(bus.add_valor) : 32'd0)
         - (consume        ? 32'd1              : 32'd0);
    rolhas_n = (soma > 32'(CAP_MAX)) ? CAP_W : soma[W-1:0];
  end

  always_comb begin
    state_n = state;
    code_n  = code;
    timer_n = timer;
    if (!bus.enable) begin
      state_n = IDLE;
      code_n  = 2'd0;
      timer_n = '0;
    end else begin
      case (state)
        IDLE: begin
          timer_n = '0;
          if (rolhas_r != '0) begin
            state_n = AVANCA;
          end else begin
            state_n = ALARME;
            code_n  = 2'd1;
          end
        end
        AVANCA: begin
          if (bus.pg) begin
            state_n = ENCHE;
            timer_n = '0;
          end
        end
        ENCHE: begin
          if (bus.ch) begin
            state_n = VEDA;
            timer_n = '0;
          end else if (timer == T_ENCHE_LIM) begin
            state_n = ALARME;
            code_n  = 2'd2;
            timer_n = '0;
          end else begin
            timer_n = timer + TW'(1);
          end
        end
        VEDA: begin
          if (bus.cq) begin
            timer_n = '0;
            // Decision uses the post-update count so a last cork plus a
            // simultaneous refill keeps the line running.
            if (rolhas_n != '0) begin
              state_n = AVANCA;
            end else begin
              state_n = ALARME;
              code_n  = 2'd1;
            end
          end else if (timer == T_VEDA_LIM) begin
            state_n = ALARME;
            code_n  = 2'd3;
            timer_n = '0;
          end else begin
            timer_n = timer + TW'(1);
          end
        end
        ALARME: begin
          if (code == 2'd1 && rolhas_r != '0) begin
            state_n = AVANCA;
            code_n  = 2'd0;
            timer_n = '0;
          end
        end
        default: begin
          state_n = IDLE;
          code_n  = 2'd0;
          timer_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      code     <= 2'd0;
      timer    <= '0;
      m_r      <= 1'b0;
      ev_r     <= 1'b0;
      ve_r     <= 1'b0;
      al_r     <= 1'b0;
      rolhas_r <= '0;
      gar      <= 4'd0;
      duz      <= 4'd0;
      lote     <= 1'b0;
      req      <= 1'b0;
      armed    <= 1'b1;
    end else begin
      state    <= state_n;
      code     <= code_n;
      timer    <= timer_n;
      m_r      <= (state_n == AVANCA);
      ev_r     <= (state_n == ENCHE);
      ve_r     <= (state_n == VEDA);
      al_r     <= (state_n == ALARME);
      rolhas_r <= rolhas_n;

      // armed records that the feeder ack has been low since the last accept,
      // so a held ack cannot satisfy a fresh request.
      if (ack_accept) begin
        req <= 1'b0;
      end else if (!req && armed && rolhas_r < MIN_W) begin
        req <= 1'b1;
      end
      if (ack_accept) begin
        armed <= 1'b0;
      end else if (!bus.refill_ack) begin
        armed <= 1'b1;
      end

      lote <= 1'b0;
      if (consume) begin
        if (gar == GAR_LAST) begin
          gar <= 4'd0;
          if (duz == DUZ_LAST) begin
            duz  <= 4'd0;
            lote <= 1'b1;
          end else begin
            duz <= duz + 4'd1;
          end
        end else begin
          gar <= gar + 4'd1;
        end
      end
    end
  end

`ifdef DISPLAY_BCD_EN
  localparam logic [W-1:0] TEN_W = W'(10);
  logic [7:0] rolhas_bcd_r, gar_bcd_r;

  always_ff @(posedge clk) begin
    if (clr) begin
      rolhas_bcd_r <= 8'h00;
      gar_bcd_r    <= 8'h00;
    end else begin
      rolhas_bcd_r <= {4'(rolhas_r / TEN_W), 4'(rolhas_r % TEN_W)};
      gar_bcd_r    <= {4'(duz / 4'd10), 4'(duz % 4'd10)};
    end
  end

  assign bus.rolhas_bcd         = rolhas_bcd_r;
  assign bus.garrafas_total_bcd = gar_bcd_r;
`endif

  assign bus.m          = m_r;
  assign bus.ev         = ev_r;
  assign bus.ve         = ve_r;
  assign bus.al         = al_r;
  assign bus.alarm_code = code;
  assign bus.refill_req = req;
  assign bus.estado     = state;
  assign bus.rolhas     = rolhas_r;
  assign bus.garrafas   = gar;
  assign bus.duzias     = duz;
  assign bus.lote_fim   = lote;

endmodule

// File: tb/tb_modulo_envase_vedacao_param.sv
// Scoreboard bench for modulo_envase_vedacao_param: the driver applies inputs
// on the falling edge, advances a behavioural model and queues the expected
// post-edge outputs; the monitor pops and compares after every rising edge.
module tb_modulo_envase_vedacao_param;
  localparam int W          = 7;
  localparam int CAP_MAX    = 99;
  localparam int MIN_ROLHAS = 5;
  localparam int RECARGA    = 20;
  localparam int DUZIA      = 12;
  localparam int DEZ_DUZIAS = 10;
  localparam int T_ENCHE    = 64;
  localparam int T_VEDA     = 16;

  localparam int S_IDLE = 0, S_AVANCA = 1, S_ENCHE = 2, S_VEDA = 3, S_ALARME = 4;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  modulo_envase_vedacao_param_if #(.W(W)) bus ();

  modulo_envase_vedacao_param #(
    .W(W), .CAP_MAX(CAP_MAX), .MIN_ROLHAS(MIN_ROLHAS), .RECARGA(RECARGA),
    .DUZIA(DUZIA), .DEZ_DUZIAS(DEZ_DUZIAS), .T_ENCHE(T_ENCHE), .T_VEDA(T_VEDA)
  ) u_dut (
    .clk(clk),
    .clr(clr),
    .bus(bus.slave)
  );

  typedef struct {
    int estado, m, ev, ve, al, code, req, rolhas, gar, duz, lote;
`ifdef DISPLAY_BCD_EN
    int rbcd, gbcd;
`endif
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: bottles are a single running total within the batch,
  // watchdogs count cycles spent waiting in the current state.
  int md_state, md_code, md_wait, md_corks, md_bottles, md_req, md_ack_low, md_lote;
  int md_rbcd, md_gbcd;
  bit auto_ack = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    md_state = S_IDLE; md_code = 0; md_wait = 0; md_corks = 0; md_bottles = 0;
    md_req = 0; md_ack_low = 1; md_lote = 0; md_rbcd = 0; md_gbcd = 0;
  endfunction

  function automatic void model_step();
    int accept, use_cork, total, new_corks, nxt, new_req, new_ack_low;
    if (clr) begin
      model_reset();
      return;
    end
    md_rbcd = (md_corks / 10) * 16 + (md_corks % 10);
    md_gbcd = ((md_bottles / DUZIA) / 10) * 16 + ((md_bottles / DUZIA) % 10);
    accept   = (md_req != 0 && bus.refill_ack) ? 1 : 0;
    use_cork = (md_state == S_VEDA && bus.enable && bus.cq && md_corks > 0) ? 1 : 0;
    total = md_corks + (accept != 0 ? RECARGA : 0)
          + (bus.add_rolhas ? int'(bus.add_valor) : 0) - use_cork;
    new_corks = (total > CAP_MAX) ? CAP_MAX : total;

    if (accept != 0) new_req = 0;
    else if (md_req == 0 && md_ack_low != 0 && md_corks < MIN_ROLHAS) new_req = 1;
    else new_req = md_req;
    if (accept != 0) new_ack_low = 0;
    else if (!bus.refill_ack) new_ack_low = 1;
    else new_ack_low = md_ack_low;

    md_lote = 0;
    if (use_cork != 0) begin
      md_bottles = (md_bottles + 1) % (DUZIA * DEZ_DUZIAS);
      md_lote = (md_bottles == 0) ? 1 : 0;
    end

    nxt = md_state;
    if (!bus.enable) begin
      nxt = S_IDLE; md_code = 0;
    end else begin
      case (md_state)
        S_IDLE: begin
          if (md_corks > 0) nxt = S_AVANCA;
          else begin nxt = S_ALARME; md_code = 1; end
        end
        S_AVANCA: if (bus.pg) nxt = S_ENCHE;
        S_ENCHE: begin
          if (bus.ch) nxt = S_VEDA;
          else begin
            md_wait++;
            if (md_wait == T_ENCHE) begin nxt = S_ALARME; md_code = 2; end
          end
        end
        S_VEDA: begin
          if (bus.cq) begin
            if (new_corks > 0) nxt = S_AVANCA;
            else begin nxt = S_ALARME; md_code = 1; end
          end else begin
            md_wait++;
            if (md_wait == T_VEDA) begin nxt = S_ALARME; md_code = 3; end
          end
        end
        default: begin
          if (md_code == 1 && md_corks > 0) begin nxt = S_AVANCA; md_code = 0; end
        end
      endcase
    end
    if (nxt != md_state) md_wait = 0;
    md_state   = nxt;
    md_corks   = new_corks;
    md_req     = new_req;
    md_ack_low = new_ack_low;
  endfunction

  task automatic tick();
    exp_t e;
    if (auto_ack) bus.refill_ack = (md_req != 0);
    model_step();
    e.estado = md_state;
    e.m  = (md_state == S_AVANCA) ? 1 : 0;
    e.ev = (md_state == S_ENCHE)  ? 1 : 0;
    e.ve = (md_state == S_VEDA)   ? 1 : 0;
    e.al = (md_state == S_ALARME) ? 1 : 0;
    e.code = md_code; e.req = md_req; e.rolhas = md_corks;
    e.gar = md_bottles % DUZIA; e.duz = md_bottles / DUZIA; e.lote = md_lote;
`ifdef DISPLAY_BCD_EN
    e.rbcd = md_rbcd; e.gbcd = md_gbcd;
`endif
    q.push_back(e);
    @(negedge clk);
    bus.add_rolhas = 1'b0;
  endtask

  task automatic bottle();
    bus.pg = 1'b1; tick(); bus.pg = 1'b0;
    bus.ch = 1'b1; tick(); bus.ch = 1'b0;
    bus.cq = 1'b1; tick(); bus.cq = 1'b0;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("estado",     int'(bus.estado),     e.estado);
        chk("m",          int'(bus.m),          e.m);
        chk("ev",         int'(bus.ev),         e.ev);
        chk("ve",         int'(bus.ve),         e.ve);
        chk("al",         int'(bus.al),         e.al);
        chk("alarm_code", int'(bus.alarm_code), e.code);
        chk("refill_req", int'(bus.refill_req), e.req);
        chk("rolhas",     int'(bus.rolhas),     e.rolhas);
        chk("garrafas",   int'(bus.garrafas),   e.gar);
        chk("duzias",     int'(bus.duzias),     e.duz);
        chk("lote_fim",   int'(bus.lote_fim),   e.lote);
`ifdef DISPLAY_BCD_EN
        chk("rolhas_bcd",         int'(bus.rolhas_bcd),         e.rbcd);
        chk("garrafas_total_bcd", int'(bus.garrafas_total_bcd), e.gbcd);
`endif
      end
    end
  end

  // Driver
  initial begin
    int mode;
    model_reset();
    clr = 1'b1;
    bus.enable = 1'b0; bus.pg = 1'b0; bus.ch = 1'b0; bus.cq = 1'b0;
    bus.add_rolhas = 1'b0; bus.add_valor = '0; bus.refill_ack = 1'b0;
    @(negedge clk);
    tick(); tick();
    clr = 1'b0;

    // Empty tray alarm and first refill
    bus.enable = 1'b1; tick();
    chk("tp_empty_estado", int'(bus.estado), 4);
    chk("tp_empty_code", int'(bus.alarm_code), 1);
    chk("tp_empty_req", int'(bus.refill_req), 1);
    bus.refill_ack = 1'b1; tick();
    chk("tp_refill_rolhas", int'(bus.rolhas), 20);
    chk("tp_refill_req", int'(bus.refill_req), 0);
    bus.refill_ack = 1'b0; tick();
    chk("tp_resume_estado", int'(bus.estado), 1);
    chk("tp_resume_m", int'(bus.m), 1);

    // One bottle, then run through a batch wrap
    bottle();
    chk("tp_bottle_rolhas", int'(bus.rolhas), 19);
    chk("tp_bottle_garrafas", int'(bus.garrafas), 1);
    auto_ack = 1;
    repeat (124) bottle();
    chk("tp_batch_garrafas", int'(bus.garrafas), 5);
    chk("tp_batch_duzias", int'(bus.duzias), 0);

    // Fill watchdog boundary
    bus.pg = 1'b1; tick(); bus.pg = 1'b0;
    repeat (T_ENCHE - 1) tick();
    chk("tp_fill_still", int'(bus.estado), 2);
    tick();
    chk("tp_fill_to_estado", int'(bus.estado), 4);
    chk("tp_fill_to_code", int'(bus.alarm_code), 2);
    chk("tp_fill_to_ev", int'(bus.ev), 0);
    bus.enable = 1'b0; tick();
    chk("tp_disable_estado", int'(bus.estado), 0);
    chk("tp_disable_code", int'(bus.alarm_code), 0);
    bus.enable = 1'b1; tick();

    // Seal watchdog boundary
    bus.pg = 1'b1; tick(); bus.pg = 1'b0;
    bus.ch = 1'b1; tick(); bus.ch = 1'b0;
    repeat (T_VEDA - 1) tick();
    chk("tp_seal_still", int'(bus.estado), 3);
    tick();
    chk("tp_seal_to_code", int'(bus.alarm_code), 3);
    bus.enable = 1'b0; tick();
    bus.enable = 1'b1;

    // Saturation with refill, add and consume together
    auto_ack = 0; bus.refill_ack = 1'b0;
    clr = 1'b1; tick(); clr = 1'b0;
    bus.enable = 1'b0;
    bus.add_rolhas = 1'b1; bus.add_valor = 7'd4; tick();
    chk("tp_low_rolhas", int'(bus.rolhas), 4);
    chk("tp_low_req", int'(bus.refill_req), 1);
    bus.enable = 1'b1; tick();
    bus.pg = 1'b1; tick(); bus.pg = 1'b0;
    bus.ch = 1'b1; tick(); bus.ch = 1'b0;
    bus.cq = 1'b1; bus.refill_ack = 1'b1;
    bus.add_rolhas = 1'b1; bus.add_valor = 7'd95; tick();
    bus.cq = 1'b0; bus.refill_ack = 1'b0;
    chk("tp_sat_rolhas", int'(bus.rolhas), 99);
    bus.add_rolhas = 1'b1; bus.add_valor = 7'd127; tick();
    chk("tp_sat_add_rolhas", int'(bus.rolhas), 99);

    // Reset in the middle of a fill
    bus.pg = 1'b1; tick(); bus.pg = 1'b0;
    chk("tp_clr_pre_ev", int'(bus.ev), 1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("tp_clr_estado", int'(bus.estado), 0);
    chk("tp_clr_ev", int'(bus.ev), 0);
    chk("tp_clr_rolhas", int'(bus.rolhas), 0);
    chk("tp_clr_garrafas", int'(bus.garrafas), 0);
    chk("tp_clr_duzias", int'(bus.duzias), 0);
    chk("tp_clr_req", int'(bus.refill_req), 0);

    // Randomized phase; some blocks starve ch/cq to exercise the watchdogs
    for (int blk = 0; blk < 15; blk++) begin
      mode = $urandom_range(0, 3);
      auto_ack = ($urandom_range(0, 1) == 0);
      for (int i = 0; i < 200; i++) begin
        clr        = ($urandom_range(0, 299) == 0);
        bus.enable = ($urandom_range(0, 19) != 0);
        bus.pg     = ($urandom_range(0, 2) == 0);
        bus.ch     = (mode != 0) && ($urandom_range(0, 2) == 0);
        bus.cq     = (mode != 0) && ($urandom_range(0, 2) == 0);
        bus.add_rolhas = ($urandom_range(0, 15) == 0);
        bus.add_valor  = W'($urandom);
        bus.refill_ack = ($urandom_range(0, 1) == 0);
        tick();
      end
    end
    clr = 1'b0;
    tick();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/modulo_envase_vedacao_param.md
Name: modulo_envase_vedacao_param

Overview:
Parametrised successor to the bottle fill/seal controller. It covers the bottle-handling FSM, cork tray (bandeja) accounting, dozen/batch counting and fault timeouts in one clocked block. Tray capacity, refill quantity, threshold, dozen size and timeouts are all generics. Adds a req/ack refill handshake with the cork feeder, fill and seal watchdogs, and coded alarms. Sits between the debounced plant sensors and the display/actuator layer.

Parameters:
W, 7, cork-count width
CAP_MAX, 99, tray capacity (saturation value)
MIN_ROLHAS, 5, refill request when count < MIN_ROLHAS
RECARGA, 20, corks added per acknowledged refill; constraint MIN_ROLHAS-1+RECARGA <= CAP_MAX
DUZIA, 12, bottles per dozen
DEZ_DUZIAS, 10, dozens per batch
T_ENCHE, 64, fill watchdog in cycles
T_VEDA, 16, seal watchdog in cycles

Ports:
clk  in  1  clock; all state changes on rising edge
clr  in  1  synchronous active-high reset
enable  in  1  start/stop level
pg  in  1  bottle in position
ch  in  1  bottle full
cq  in  1  cork inserted confirmation
add_rolhas  in  1  single-cycle operator add strobe
add_valor  in  W  operator add quantity
refill_ack  in  1  feeder acknowledge
m  out  1  conveyor motor
ev  out  1  fill valve
ve  out  1  sealer
al  out  1  alarm
alarm_code  out  2  0 none, 1 no cork, 2 fill timeout, 3 seal timeout
refill_req  out  1  feeder request
estado  out  3  FSM state
rolhas  out  W  corks in tray
garrafas  out  4  bottles in current dozen, 0..DUZIA-1
duzias  out  4  dozens in current batch, 0..DEZ_DUZIAS-1
lote_fim  out  1  one-cycle pulse on batch wrap

Behaviour:
- clr (sync): estado=IDLE; all outputs 0; rolhas=0; timer=0. clr overrides every other input. clr mid-operation drops actuators on the same edge.
- States: IDLE=0, AVANCA=1, ENCHE=2, VEDA=3, ALARME=4. Outputs are registered Moore outputs: m=AVANCA, ev=ENCHE, ve=VEDA, al=ALARME.
- enable=0 in any state -> IDLE next edge; alarm_code:=0. Counters and rolhas hold.
- IDLE:
  - enable=1 and rolhas>0 -> AVANCA.
  - enable=1 and rolhas=0 -> ALARME with code 1.
- AVANCA: pg=1 -> ENCHE; timer:=0.
- ENCHE:
  - ch=1 -> VEDA; timer:=0.
  - otherwise timer++; timer reaching T_ENCHE-1 -> ALARME with code 2.
- VEDA:
  - cq=1 -> consume one cork and count one bottle. Then -> AVANCA if next rolhas>0, else ALARME with code 1.
  - otherwise timer++; timer reaching T_VEDA-1 -> ALARME with code 3.
- ALARME:
  - Code 1 self-clears when rolhas>0 -> AVANCA; code:=0.
  - Codes 2 and 3 are latched; they clear only through enable=0 or clr.
- Cork update, once per cycle: next = rolhas + (ack_accept ? RECARGA : 0) + (add_rolhas ? add_valor : 0) - (consume ? 1 : 0).
  - Clamp to CAP_MAX.
  - Consume never occurs with rolhas=0.
  - Add, refill and consume in the same cycle all apply (net sum).
- Refill handshake:
  - refill_req rises the cycle after rolhas < MIN_ROLHAS is seen with no request pending.
  - It holds until refill_ack=1 is sampled (ack_accept); req deasserts on the next edge.
  - A new request requires refill_ack to have been seen low for at least one cycle.
  - refill_ack while req=0 is ignored.
  - Refill runs independently of enable and FSM state.
- Bottle count on consume:
  - garrafas==DUZIA-1 -> garrafas:=0 and duzias++.
  - duzias==DEZ_DUZIAS-1 on that increment -> duzias:=0 and lote_fim=1 for one cycle.
- Timer width: clog2(max(T_ENCHE,T_VEDA)). Timer is cleared on every state entry.

Optional Feature:
- Macro DISPLAY_BCD_EN.
- Defined: adds outputs rolhas_bcd (8 bits, tens[7:4] and units[3:0]) and garrafas_total_bcd (8 bits, duzias tens/units). Both are registered with 1-cycle latency after the source changes and reset to 0x00. Requires CAP_MAX <= 99.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- clr; enable=1, rolhas=0 -> estado=4, alarm_code=1, refill_req=1. Pulse refill_ack for 1 cycle -> rolhas=20, req=0. Next cycle estado=1, m=1.
- rolhas=20; pulse pg, ch, cq in turn -> states 1->2->3->1, rolhas=19, garrafas=1, ev and ve each high exactly while in their state.
- 12 full bottle cycles -> garrafas=0, duzias=1. 120 cycles -> lote_fim single-cycle pulse, duzias=0.
- In ENCHE hold ch=0 -> after 64 cycles estado=4, alarm_code=2, ev=0. Then enable=0 -> estado=0, code 0.
- rolhas=4: req asserts. Same cycle: refill_ack=1, add_rolhas=1, add_valor=95 -> rolhas=99 (saturated). Consume on the same cycle also yields 99.
- clr asserted in ENCHE with ev=1 -> next edge all outputs 0, estado=0, rolhas=0, counters 0.
